// File: rtl/screen_sequencer.sv
// Cycles a VGA/status output between NUM_SCREENS sources when the current screen requests it.
// Define SCREEN_SEQ_FRAME_ALIGN_EN to hold each switch until the current screen's vsync falls.
module screen_sequencer #(
  parameter int NUM_SCREENS = 3,
  parameter int COLOR_W     = 4,
  parameter int BTN_W       = 3,
  parameter int WAIT_MAX    = 1000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SCREENS*COLOR_W-1:0] r_in,
  input  logic [NUM_SCREENS*COLOR_W-1:0] g_in,
  input  logic [NUM_SCREENS*COLOR_W-1:0] b_in,
  input  logic [NUM_SCREENS-1:0]         hs_in,
  input  logic [NUM_SCREENS-1:0]         vs_in,
  input  logic [NUM_SCREENS*BTN_W-1:0]   btn_in,
  input  logic [NUM_SCREENS-1:0]         adv_req,
  output logic [COLOR_W-1:0]             VGA_R,
  output logic [COLOR_W-1:0]             VGA_G,
  output logic [COLOR_W-1:0]             VGA_B,
  output logic                           VGA_HS,
  output logic                           VGA_VS,
  output logic [BTN_W-1:0]               btn,
  output logic [$clog2(NUM_SCREENS)-1:0] screen_idx,
  output logic                           switch_pulse,
  output logic                           pending
);

  localparam int IDX_W = $clog2(NUM_SCREENS);

  if (NUM_SCREENS < 2 || NUM_SCREENS > 8 || WAIT_MAX < 2) begin : g_bad_params
    $error("screen_sequencer: illegal parameter value");
  end

  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               hs_q, hs_d, vs_q, vs_d;
  logic [BTN_W-1:0]   btn_q, btn_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
  logic               pulse_q, pulse_d;
  logic               cur_adv;

  // Output mux always follows the index held before the edge, so a switch
  // shows up on the data outputs one cycle after screen_idx changes.
  always_comb begin
    cur_adv = adv_req[idx_q];
    idx_inc = (idx_q == IDX_W'(NUM_SCREENS - 1)) ? '0 : idx_q + 1'b1;
    r_d     = r_in[idx_q*COLOR_W +: COLOR_W];
    g_d     = g_in[idx_q*COLOR_W +: COLOR_W];
    b_d     = b_in[idx_q*COLOR_W +: COLOR_W];
    hs_d    = hs_in[idx_q];
    vs_d    = vs_in[idx_q];
    btn_d   = btn_in[idx_q*BTN_W +: BTN_W];
  end

`ifdef SCREEN_SEQ_FRAME_ALIGN_EN
  localparam int CNT_W = $clog2(WAIT_MAX) + 1;

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] next_q, next_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vs_prev_q, vs_prev_d;
  logic             cur_vs;
  logic             commit;

  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pulse_d   = 1'b0;
    commit    = 1'b0;
    cur_vs    = vs_in[idx_q];
    vs_prev_d = cur_vs;
    case (state_q)
      IDLE: begin
        if (cur_adv) begin
          state_d = PEND;
          next_d  = idx_inc;
          cnt_d   = '0;
        end
      end
      PEND: begin
        commit = (vs_prev_q && !cur_vs) || (cnt_q == CNT_W'(WAIT_MAX - 1));
        if (commit) begin
          state_d   = IDLE;
          idx_d     = next_q;
          pulse_d   = 1'b1;
          cnt_d     = '0;
          // Clearing the history means the new screen needs a fresh 1->0.
          vs_prev_d = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      next_q    <= '0;
      cnt_q     <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      next_q    <= next_d;
      cnt_q     <= cnt_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign pending = (state_q == PEND);
`else
  always_comb begin
    idx_d   = idx_q;
    pulse_d = 1'b0;
    if (cur_adv) begin
      idx_d   = idx_inc;
      pulse_d = 1'b1;
    end
  end

  assign pending = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      btn_q   <= '0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      btn_q   <= btn_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
    end
  end

  assign VGA_R        = r_q;
  assign VGA_G        = g_q;
  assign VGA_B        = b_q;
  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign btn          = btn_q;
  assign screen_idx   = idx_q;
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: reset values, routing table, switch sequencing.
module tb_screen_sequencer;

  localparam int NS = 3;
  localparam int CW = 4;
  localparam int BW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS*CW-1:0]  r_in, g_in, b_in;
  logic [NS-1:0]     hs_in, vs_in, adv_req;
  logic [NS*BW-1:0]  btn_in;
  logic [CW-1:0]     vga_r, vga_g, vga_b;
  logic              vga_hs, vga_vs;
  logic [BW-1:0]     btn;
  logic [1:0]        screen_idx;
  logic              switch_pulse, pending;

  int n_tests = 0;
  int n_fail  = 0;
  int pend_seen = 0;
  int errs;

  always #5 clk = ~clk;

  screen_sequencer #(.NUM_SCREENS(NS), .COLOR_W(CW), .BTN_W(BW)) dut (
    .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .btn_in(btn_in), .adv_req(adv_req),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
    .btn(btn), .screen_idx(screen_idx), .switch_pulse(switch_pulse), .pending(pending)
  );

`ifdef SCREEN_SEQ_FRAME_ALIGN_EN
  logic [CW-1:0] wd_r, wd_g, wd_b;
  logic          wd_hs, wd_vs;
  logic [BW-1:0] wd_btn;
  logic [1:0]    wd_idx;
  logic          wd_pulse, wd_pending;

  screen_sequencer #(.NUM_SCREENS(NS), .COLOR_W(CW), .BTN_W(BW), .WAIT_MAX(16)) dut_wd (
    .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .btn_in(btn_in), .adv_req(adv_req),
    .VGA_R(wd_r), .VGA_G(wd_g), .VGA_B(wd_b), .VGA_HS(wd_hs), .VGA_VS(wd_vs),
    .btn(wd_btn), .screen_idx(wd_idx), .switch_pulse(wd_pulse), .pending(wd_pending)
  );
`endif

  always @(negedge clk) if (pending === 1'b1) pend_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] adv, hs, vs;
    int         idx;
    logic       pulse;
    logic [3:0] r, g, b;
    logic [2:0] btn_e;
    logic       hs_e, vs_e;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Screen i colours: r = i+1, g = i+4, b = i+7; status 1, 2, 4.
    r_in    = 12'h321;
    g_in    = 12'h654;
    b_in    = 12'h987;
    btn_in  = 9'b100_010_001;
    hs_in   = 3'b000;
    vs_in   = 3'b000;
    adv_req = 3'b000;
    reset   = 1'b0;

    repeat (4) @(negedge clk);
    check("rst_idx", screen_idx, 0);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_r", vga_r, 0);
    check("rst_btn", btn, 0);
    check("rst_pulse", switch_pulse, 0);
    check("rst_pending", pending, 0);

    reset = 1'b1;
    hs_in = 3'b110;
    vs_in = 3'b110;
    @(negedge clk);
    check("rel_r", vga_r, 4'h1);
    check("rel_hs", vga_hs, 0);
    check("rel_idx", screen_idx, 0);

`ifndef SCREEN_SEQ_FRAME_ALIGN_EN
    //          adv     hs      vs      idx pulse r     g     b     btn   hs    vs
    vecs[0]  = '{3'b000, 3'b110, 3'b101, 0, 1'b0, 4'h1, 4'h4, 4'h7, 3'd1, 1'b0, 1'b1};
    vecs[1]  = '{3'b110, 3'b001, 3'b010, 0, 1'b0, 4'h1, 4'h4, 4'h7, 3'd1, 1'b1, 1'b0};
    vecs[2]  = '{3'b001, 3'b011, 3'b100, 1, 1'b1, 4'h1, 4'h4, 4'h7, 3'd1, 1'b1, 1'b0};
    vecs[3]  = '{3'b000, 3'b010, 3'b101, 1, 1'b0, 4'h2, 4'h5, 4'h8, 3'd2, 1'b1, 1'b0};
    vecs[4]  = '{3'b101, 3'b101, 3'b010, 1, 1'b0, 4'h2, 4'h5, 4'h8, 3'd2, 1'b0, 1'b1};
    vecs[5]  = '{3'b010, 3'b000, 3'b111, 2, 1'b1, 4'h2, 4'h5, 4'h8, 3'd2, 1'b0, 1'b1};
    vecs[6]  = '{3'b010, 3'b100, 3'b011, 2, 1'b0, 4'h3, 4'h6, 4'h9, 3'd4, 1'b1, 1'b0};
    vecs[7]  = '{3'b100, 3'b011, 3'b100, 0, 1'b1, 4'h3, 4'h6, 4'h9, 3'd4, 1'b0, 1'b1};
    vecs[8]  = '{3'b001, 3'b110, 3'b001, 1, 1'b1, 4'h1, 4'h4, 4'h7, 3'd1, 1'b0, 1'b1};
    vecs[9]  = '{3'b010, 3'b111, 3'b000, 2, 1'b1, 4'h2, 4'h5, 4'h8, 3'd2, 1'b1, 1'b0};
    vecs[10] = '{3'b000, 3'b011, 3'b100, 2, 1'b0, 4'h3, 4'h6, 4'h9, 3'd4, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      adv_req = vecs[i].adv;
      hs_in   = vecs[i].hs;
      vs_in   = vecs[i].vs;
      @(negedge clk);
      check($sformatf("v%0d_idx", i), screen_idx, vecs[i].idx);
      check($sformatf("v%0d_pulse", i), switch_pulse, vecs[i].pulse);
      check($sformatf("v%0d_pending", i), pending, 0);
      check($sformatf("v%0d_r", i), vga_r, vecs[i].r);
      check($sformatf("v%0d_g", i), vga_g, vecs[i].g);
      check($sformatf("v%0d_b", i), vga_b, vecs[i].b);
      check($sformatf("v%0d_btn", i), btn, vecs[i].btn_e);
      check($sformatf("v%0d_hs", i), vga_hs, vecs[i].hs_e);
      check($sformatf("v%0d_vs", i), vga_vs, vecs[i].vs_e);
    end

    // Reset from screen 2 with a live request: index returns to 0, no strobe.
    reset   = 1'b0;
    adv_req = 3'b100;
    @(negedge clk);
    check("midrst_idx", screen_idx, 0);
    check("midrst_pulse", switch_pulse, 0);
    check("midrst_hs", vga_hs, 1);

    reset   = 1'b1;
    adv_req = 3'b001;
    @(negedge clk);
    check("imm_idx", screen_idx, 1);
    check("imm_pulse", switch_pulse, 1);
    adv_req = 3'b000;
    @(negedge clk);
    check("imm_pulse_end", switch_pulse, 0);
    check("imm_idx_hold", screen_idx, 1);
    check("pending_never", pend_seen, 0);
`else
    // Request from screen 0, vsync falls 200 cycles after PEND entry.
    vs_in   = 3'b111;
    adv_req = 3'b001;
    @(negedge clk);
    adv_req = 3'b000;
    check("pend_entry", pending, 1);
    errs = 0;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (pending !== 1'b1 || switch_pulse !== 1'b0) errs++;
      if (k == 199) vs_in = 3'b110;
    end
    check("pend_hold", errs, 0);
    @(negedge clk);
    check("edge_pulse", switch_pulse, 1);
    check("edge_idx", screen_idx, 1);
    check("edge_pending", pending, 0);
    @(negedge clk);
    check("edge_pulse_end", switch_pulse, 0);
    vs_in = 3'b111;

    // Watchdog (16) from screen 1 with vsync held high.
    check("wd_start_idx", wd_idx, 1);
    adv_req = 3'b010;
    @(negedge clk);
    check("wd_pend", wd_pending, 1);
    errs = 0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (wd_pulse !== 1'b0 || wd_pending !== 1'b1) errs++;
    end
    check("wd_wait", errs, 0);
    @(negedge clk);
    check("wd_pulse", wd_pulse, 1);
    check("wd_idx", wd_idx, 2);
    adv_req = 3'b000;

    // Main instance still pending on screen 1: commit by a vsync edge.
    vs_in = 3'b101;
    @(negedge clk);
    check("s1_pulse", switch_pulse, 1);
    check("s1_idx", screen_idx, 2);

    // Wrap 2 -> 0, then a held adv_req[0] opens a new PEND next cycle.
    vs_in   = 3'b111;
    adv_req = 3'b101;
    @(negedge clk);
    check("wrap_pend", pending, 1);
    vs_in = 3'b011;
    @(negedge clk);
    check("wrap_pulse", switch_pulse, 1);
    check("wrap_idx", screen_idx, 0);
    @(negedge clk);
    check("repend", pending, 1);
    check("repend_pulse", switch_pulse, 0);
    check("repend_idx", screen_idx, 0);

    // Move to screen 1 with its request held, then reset 5 cycles into PEND.
    vs_in   = 3'b010;
    adv_req = 3'b010;
    @(negedge clk);
    check("s0_idx", screen_idx, 1);
    @(negedge clk);
    check("s1_repend", pending, 1);
    adv_req = 3'b000;
    errs = 0;
    repeat (4) begin
      @(negedge clk);
      if (switch_pulse !== 1'b0) errs++;
    end
    check("pend5_nopulse", errs, 0);
    reset = 1'b0;
    @(negedge clk);
    check("prst_pending", pending, 0);
    check("prst_idx", screen_idx, 0);
    check("prst_pulse", switch_pulse, 0);
    reset = 1'b1;
    @(negedge clk);
    check("prst_after_pulse", switch_pulse, 0);
    check("prst_after_pending", pending, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter NUM_SCREENS, default 3: number of screen sources, legal range 2..8.
REQ-002 Parameter COLOR_W, default 4: bits per colour channel.
REQ-003 Parameter BTN_W, default 3: width of each screen's LED/button status bus.
REQ-004 Parameter WAIT_MAX, default 1000000: watchdog limit in clk cycles for a pending switch.
REQ-005 clk  input  1  system clock; the block uses this one clock only.
REQ-006 reset  input  1  reset that is synchronous to clk and active-low.
REQ-007 r_in, g_in, b_in  input  NUM_SCREENS*COLOR_W each  packed colour buses; screen i occupies bits [i*COLOR_W +: COLOR_W].
REQ-008 hs_in, vs_in  input  NUM_SCREENS each  per-screen syncs, active-low.
REQ-009 btn_in  input  NUM_SCREENS*BTN_W  packed per-screen status buses.
REQ-010 adv_req  input  NUM_SCREENS  bit i: screen i requests advance (level).
REQ-011 VGA_R, VGA_G, VGA_B  output  COLOR_W each  selected colour, registered.
REQ-012 VGA_HS, VGA_VS  output  1 each  selected syncs, registered.
REQ-013 btn  output  BTN_W  selected status bus, registered.
REQ-014 screen_idx  output  clog2(NUM_SCREENS)  current screen index.
REQ-015 switch_pulse  output  1  one-cycle strobe on each committed switch.
REQ-016 pending  output  1  high while a switch is waiting to commit.

Function
REQ-017 Outputs SHALL equal the inputs of screen screen_idx, registered with exactly 1 clk of latency.
REQ-018 FSM states SHALL be IDLE and PEND.
REQ-019 In IDLE, adv_req[screen_idx]=1 SHALL move the FSM to PEND and latch next = screen_idx+1, wrapping from NUM_SCREENS-1 to 0.
REQ-020 adv_req bits of non-current screens SHALL be ignored.
REQ-021 In PEND, the switch SHALL commit on the first cycle in which vs_in[screen_idx] shows a 1->0 edge, detected against the previous cycle's sampled value.
REQ-022 On commit: screen_idx<=next, switch_pulse=1 for one cycle, return to IDLE, and the wait counter clears.
REQ-023 In PEND, the wait counter SHALL increment every cycle; when it reaches WAIT_MAX-1 without an edge, the switch SHALL commit anyway.
REQ-024 adv_req activity during PEND SHALL be ignored, with no queueing.
REQ-025 After a commit, a still-asserted adv_req on the new screen SHALL start a new PEND from the next cycle; the block never skips two screens in one cycle.
REQ-026 The vsync edge detector SHALL re-arm on commit so that the new screen's sync history cannot cause an immediate commit.
REQ-027 The wait counter width SHALL be clog2(WAIT_MAX)+1 and the counter SHALL saturate, never wrapping.

Reset
REQ-028 While reset=0 at a clk edge, the block SHALL set: state IDLE, screen_idx 0, pending 0, switch_pulse 0, counter 0, VGA_R/G/B 0, VGA_HS 1, VGA_VS 1, btn 0.
REQ-029 Reset asserted during PEND SHALL discard the pending switch; screen_idx returns to 0.
REQ-030 On the first cycle after reset deasserts, the outputs SHALL begin tracking screen 0 with 1-cycle latency.

Configuration
REQ-031 Macro SCREEN_SEQ_FRAME_ALIGN_EN SHALL control frame-aligned switching.
REQ-032 With SCREEN_SEQ_FRAME_ALIGN_EN defined, the PEND, vsync-edge and watchdog behaviour of REQ-021..REQ-027 applies.
REQ-033 Without SCREEN_SEQ_FRAME_ALIGN_EN, adv_req[screen_idx]=1 SHALL commit on the next clk edge: pending stays 0, and the counter and edge-detection logic are absent.

Verification
REQ-034 Reset held low for 4 cycles, then released with adv_req=0 -> screen_idx=0, VGA_HS=VGA_VS=1 during reset; one cycle later VGA_R=r_in[3:0].
REQ-035 Pulse adv_req[0] for 1 cycle; vs_in[0] falls 200 cycles later -> pending=1 for 200 cycles, then switch_pulse single cycle, screen_idx=1.
REQ-036 WAIT_MAX=16, adv_req[1]=1, vs_in[1] held high -> commit exactly 16 cycles after PEND entry; screen_idx=2.
REQ-037 screen_idx=2 with adv_req[2] set and a vsync edge -> screen_idx wraps to 0; adv_req[0] held high -> new PEND on the following cycle.
REQ-038 Reset=0 asserted 5 cycles into PEND -> pending=0 and screen_idx=0; no switch_pulse.
REQ-039 Build without SCREEN_SEQ_FRAME_ALIGN_EN, adv_req[0]=1 -> screen_idx=1 one cycle later; pending never 1.
